// File: rtl/gshare_predictor.sv
// gshare_predictor
//   Global-history branch direction predictor. A table of saturating counters
//   is indexed by the branch PC XOR a speculative global history register
//   (GHR). Each prediction returns a checkpoint (table index and pre-push
//   history) that the branch carries to resolution, where it trains the
//   counter and, on a mispredict, repairs the GHR.
//
// Ports
//   clk_in            system clock
//   rst_in            synchronous active-high reset (priority over rdy_in)
//   rdy_in            global ready; when low all state and outputs hold
//   query_valid       conditional branch presented this cycle
//   query_pc          branch PC bits [INDEX_WIDTH+1:2]
//   pred_valid        prediction for last cycle's query is valid
//   pred_taken        1 = predict taken
//   pred_index        table index used (checkpoint)
//   pred_history      GHR before this prediction's push (checkpoint)
//   update_valid      a branch resolved this cycle
//   update_index      checkpoint index of the resolved branch
//   update_history    checkpoint history of the resolved branch
//   update_taken      actual outcome
//   update_mispredict prediction was wrong (qualified by update_valid)
module gshare_predictor #(
  parameter int INDEX_WIDTH   = 8,
  parameter int HISTORY_WIDTH = 8,
  parameter int COUNTER_WIDTH = 2
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     query_valid,
  input  logic [INDEX_WIDTH-1:0]   query_pc,
  output logic                     pred_valid,
  output logic                     pred_taken,
  output logic [INDEX_WIDTH-1:0]   pred_index,
  output logic [HISTORY_WIDTH-1:0] pred_history,
  input  logic                     update_valid,
  input  logic [INDEX_WIDTH-1:0]   update_index,
  input  logic [HISTORY_WIDTH-1:0] update_history,
  input  logic                     update_taken,
  input  logic                     update_mispredict
);

  localparam int unsigned DEPTH = 1 << INDEX_WIDTH;
  localparam logic [COUNTER_WIDTH-1:0] CTR_INIT = {1'b0, {(COUNTER_WIDTH-1){1'b1}}};
  localparam logic [COUNTER_WIDTH-1:0] CTR_MAX  = '1;

  logic [COUNTER_WIDTH-1:0] r_ctr [DEPTH];
  logic [HISTORY_WIDTH-1:0] r_ghr;

  logic [INDEX_WIDTH-1:0]   w_qidx;
  logic                     w_qtaken;
  logic [HISTORY_WIDTH-1:0] w_ghr_push;
  logic [HISTORY_WIDTH-1:0] w_ghr_fix;
  logic [COUNTER_WIDTH-1:0] w_ucur;
  logic [COUNTER_WIDTH-1:0] w_unext;

  assign w_qidx   = query_pc ^ INDEX_WIDTH'(r_ghr);
  assign w_qtaken = r_ctr[w_qidx][COUNTER_WIDTH-1];

  // A one-bit history has no shift; the new bit simply replaces it.
  generate
    if (HISTORY_WIDTH == 1) begin : gen_h1
      logic w_unused_hist;
      assign w_unused_hist = update_history[0];
      assign w_ghr_push    = w_qtaken;
      assign w_ghr_fix     = update_taken;
    end else begin : gen_hn
      logic w_unused_hist;
      assign w_unused_hist = update_history[HISTORY_WIDTH-1];
      assign w_ghr_push    = {r_ghr[HISTORY_WIDTH-2:0], w_qtaken};
      assign w_ghr_fix     = {update_history[HISTORY_WIDTH-2:0], update_taken};
    end
  endgenerate

  // Saturating next value for the counter being trained.
  always_comb begin
    w_ucur  = r_ctr[update_index];
    w_unext = w_ucur;
    if (update_taken) begin
      if (w_ucur != CTR_MAX) w_unext = w_ucur + COUNTER_WIDTH'(1);
    end else begin
      if (w_ucur != '0) w_unext = w_ucur - COUNTER_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_ctr[INDEX_WIDTH'(i)] <= CTR_INIT;
      r_ghr        <= '0;
      pred_valid   <= 1'b0;
      pred_taken   <= 1'b0;
      pred_index   <= '0;
      pred_history <= '0;
    end else if (rdy_in) begin
      // The query reads r_ctr combinationally before this write lands,
      // giving read-before-write on a same-index collision.
      if (update_valid) r_ctr[update_index] <= w_unext;

      if (update_valid && update_mispredict) begin
        // Repair wins over a concurrent query, which is squashed.
        r_ghr      <= w_ghr_fix;
        pred_valid <= 1'b0;
      end else if (query_valid) begin
        r_ghr        <= w_ghr_push;
        pred_valid   <= 1'b1;
        pred_taken   <= w_qtaken;
        pred_index   <= w_qidx;
        pred_history <= r_ghr;
      end else begin
        pred_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/gshare_predictor.md
# gshare_predictor

Parametrised global-history (gshare) branch direction predictor for the instruction fetch stage. It replaces the fixed 2-bit local counter table with a table of COUNTER_WIDTH-bit saturating counters indexed by PC XOR a speculative global history register (GHR). Each prediction returns a checkpoint (the table index and the pre-push history) that travels with the branch. On resolution the checkpoint trains the counter and, on a mispredict, repairs the GHR.

## Interface
- INDEX_WIDTH, 8: log2 of the counter table depth (256 entries at default).
- HISTORY_WIDTH, 8: GHR width. Legal range 1..INDEX_WIDTH.
- COUNTER_WIDTH, 2: saturating counter width. Legal range 2..4.
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous, active-high reset.
- rdy_in  input  1  global ready. When low, all state and outputs hold.
- query_valid  input  1  fetch presents a conditional branch this cycle.
- query_pc  input  INDEX_WIDTH [INDEX_WIDTH+1:2]  branch PC bits.
- pred_valid  output  1  prediction for last cycle's query is valid.
- pred_taken  output  1  1 = predict taken.
- pred_index  output  INDEX_WIDTH  table index used; the branch carries it to resolution.
- pred_history  output  HISTORY_WIDTH  GHR value before this prediction's push; the branch carries it to resolution.
- update_valid  input  1  a branch resolved this cycle.
- update_index  input  INDEX_WIDTH  pred_index returned for that branch.
- update_history  input  HISTORY_WIDTH  pred_history returned for that branch.
- update_taken  input  1  actual branch outcome.
- update_mispredict  input  1  prediction was wrong. Ignored unless update_valid is high.

## Operation
- Table: 2^INDEX_WIDTH counters, all implemented as registers. Predict taken when counter MSB = 1.
- Reset, single cycle:
  - every counter to weakly-not-taken, 2^(COUNTER_WIDTH-1)-1 (01 at default);
  - GHR = 0;
  - pred_valid = 0, pred_taken = 0, pred_index = 0, pred_history = 0.
- Query (query_valid & rdy_in):
  - index = query_pc XOR zero-extended GHR.
  - Next edge registers: pred_valid = 1, pred_taken = counter[index] MSB, pred_index = index, pred_history = GHR.
  - Same edge: GHR <= {GHR[HISTORY_WIDTH-2:0], predicted direction} (speculative push).
  - With HISTORY_WIDTH = 1, GHR <= predicted direction.
- No query with rdy_in high: pred_valid <= 0. The other pred_* outputs hold their last values.
- Update (update_valid & rdy_in):
  - counter[update_index] increments if update_taken, otherwise decrements.
  - The counter saturates at 0 and at 2^COUNTER_WIDTH-1; no wrap.
- Mispredict (update_valid & update_mispredict & rdy_in): GHR <= {update_history[HISTORY_WIDTH-2:0], update_taken}.
- Simultaneous events:
  - Mispredict and query in the same cycle: the GHR repair wins, the query's push is discarded, and pred_valid <= 0 (the query is squashed).
  - Update and query to the same index in the same cycle: the query reads the pre-update counter value (read-before-write, no bypass).
  - Non-mispredict update and query in the same cycle: both take effect. Only the query alters the GHR.
- rdy_in low: no counter, GHR or output changes, even if the valid inputs are high.
- rst_in has priority over rdy_in. A reset mid-stream discards all history and training.

## Timing
- Query to prediction latency is exactly 1 cycle. pred_* are registered outputs.
- Back-to-back queries are allowed every cycle. Query N+1 indexes with the GHR already holding query N's predicted bit.
- Update latency is 1 cycle: a counter or GHR change is visible to a query issued on the cycle after the update.
- There is no backpressure and no handshake. Every valid input is consumed on the rdy_in-high edge it is presented.

## Test plan
Defaults INDEX_WIDTH = 8, HISTORY_WIDTH = 8, COUNTER_WIDTH = 2.
- Reset check:
  - Stimulus: reset, then query pc = 0x12.
  - Required next cycle: pred_valid = 1, pred_taken = 0, pred_index = 0x12, pred_history = 0x00.
  - GHR afterwards = 0x00.
- Saturation:
  - Stimulus: 3 updates taken to index 0x40, then a query whose index resolves to 0x40.
  - Required: taken. Counter is 11 and stays 11 after a 4th taken update.
  - Then 1 not-taken update: still taken (10). A 2nd not-taken update: not taken.
- Speculative history:
  - Stimulus: train index 0x05 to taken, then query pc 0x05 and next cycle query pc 0x05.
  - Required: second pred_index = 0x05 ^ 0x01 = 0x04, second pred_history = 0x01.
- Mispredict repair:
  - Stimulus: GHR = 0xA5, update_valid = 1, update_mispredict = 1, update_history = 0x3C, update_taken = 1, query_valid = 1 in the same cycle.
  - Required: GHR = 0x79 and pred_valid = 0 on the next cycle.
- Same-index collision:
  - Stimulus: counter 01, query and taken update to the same index in one cycle.
  - Required: pred_taken = 0. A following query to that index predicts taken.
- rdy_in stall:
  - Stimulus: hold rdy_in low for 3 cycles with query and update asserted.
  - Required: outputs, GHR and counters unchanged. Resume on rdy_in high.
